// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: central stall/flush sequencer for the 5-stage RV32I pipeline.
// Arbitrates memory wait (highest), taken-branch redirect, then load-use bubble, and
// drives the PC / pipeline-register enables and flushes.
// Optional macro STALL_PERF_CNT_EN: when defined, stall_cycles counts cycles with pc_en=0;
// when undefined, no counter flops exist and stall_cycles is tied to 0.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      id_inst,
    input  logic [31:0]      ex_inst,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {StInit, StRun, StMemWait} state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    localparam logic [7:0] TimeoutVal = 8'(MEM_TIMEOUT);
    localparam logic [7:0] TimerMax   = 8'hFF;

    state_e     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic       timeout_q, timeout_d;

    logic       uses_rs1, uses_rs2;
    logic [4:0] ex_rd;
    logic       lu;
    logic       memstall;
    logic       waiting;
    logic       advance;

    // Fields not involved in hazard detection
    logic unused_bits;
    assign unused_bits = ^{id_inst[31:25], id_inst[14:7], ex_inst[31:12]};

    // Decode which source registers the ID instruction actually reads
    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (id_inst[6:0])
            OpReg, OpStore, OpBranch: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OpImm, OpLoad, OpJalr: uses_rs1 = 1'b1;
            default: ;
        endcase
    end

    assign ex_rd    = ex_inst[11:7];
    assign lu       = (ex_inst[6:0] == OpLoad) && (ex_rd != 5'd0) &&
                      ((uses_rs1 && (id_inst[19:15] == ex_rd)) ||
                       (uses_rs2 && (id_inst[24:20] == ex_rd)));
    assign memstall = mem_req && !mem_ready;

    // Cycle spent frozen on memory: entry from RUN or continued wait
    assign waiting = ((state_q == StRun) && memstall) ||
                     ((state_q == StMemWait) && !mem_ready);
    // Cycle where branch/lu/normal rules apply (RUN without stall, or wait release)
    assign advance = ((state_q == StRun) && !memstall) ||
                     ((state_q == StMemWait) && mem_ready);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StInit;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit:    state_d = StRun;
            StRun:     if (memstall) state_d = StMemWait;
            StMemWait: if (mem_ready) state_d = StRun;
            default:   state_d = StInit;
        endcase
    end

    // Mealy outputs; frozen cycles leave every enable and flush at 0
    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        exmem_en   = 1'b0;
        if (state_q == StInit) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (advance) begin
            exmem_en = 1'b1;
            if (ex_branch_taken) begin
                pc_en      = 1'b1;
                ifid_en    = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (lu) begin
                idex_flush = 1'b1;
            end else begin
                pc_en   = 1'b1;
                ifid_en = 1'b1;
            end
        end
    end

    // Wait timer and sticky timeout next-state
    always_comb begin
        timer_d   = timer_q;
        timeout_d = timeout_q;
        if ((state_q == StRun) && memstall) begin
            timer_d = 8'd1;
        end else if ((state_q == StMemWait) && !mem_ready && (timer_q != TimerMax)) begin
            timer_d = timer_q + 8'd1;
        end
        if (waiting && (timer_d == TimeoutVal)) begin
            timeout_d = 1'b1;
        end
    end

    // Wait timer and timeout flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q   <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
        end
    end

    assign mem_timeout = timeout_q;

`ifdef STALL_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of non-INIT cycles with the PC held
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q != StInit) && !pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Stall counter flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32I pipeline. It takes three inputs: the instructions in the ID and EX stages, the EX-stage branch/jump resolution, and the data-memory handshake. From these it drives the PC and pipeline-register enables and flushes. It replaces the per-stage combinational stall logic with a single arbiter that has a defined priority:
- memory wait, highest priority;
- then taken-branch redirect;
- then load-use bubble.

Parameters:
MEM_TIMEOUT, 15, number of consecutive not-ready memory-wait cycles before mem_timeout is flagged (range 1..255)
CNT_W, 16, width of the stall performance counter

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
id_inst  input  32  instruction currently in ID (IF/ID register output)
ex_inst  input  32  instruction currently in EX (ID/EX register output)
ex_branch_taken  input  1  EX has resolved a taken branch, JAL or JALR this cycle
mem_req  input  1  MEM stage holds a load or store
mem_ready  input  1  data memory completes the MEM-stage access this cycle
pc_en  output  1  PC register load enable
ifid_en  output  1  IF/ID register load enable
ifid_flush  output  1  IF/ID register loads NOP (overrides ifid_en)
idex_flush  output  1  ID/EX register loads NOP
exmem_en  output  1  EX/MEM and MEM/WB register load enable
mem_timeout  output  1  sticky flag: memory wait exceeded MEM_TIMEOUT
stall_cycles  output  CNT_W  saturating count of cycles with pc_en=0

Behaviour:
- One clock; reset is asynchronous, active-low (clk, rst_n). The state, wait timer, mem_timeout and stall_cycles are all flops.
- States: INIT, RUN, MEM_WAIT. While rst_n=0 the state is INIT.
- Reset/INIT outputs: pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1, exmem_en=0, mem_timeout=0, stall_cycles=0.
- INIT -> RUN on the first rising edge after rst_n deasserts, unconditionally.
- Load-use hazard (lu), evaluated combinationally:
  - Condition: ex_inst[6:0]=0000011 AND ex_inst[11:7]!=0 AND (rs1_hit OR rs2_hit).
  - rs1_hit: id_inst[19:15]==ex_inst[11:7] and id opcode is one of 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
  - rs2_hit: id_inst[24:20]==ex_inst[11:7] and id opcode is one of 0110011, 0100011, 1100011.
  - The I-type immediate field is never compared.
- memstall = mem_req AND NOT mem_ready.
- Outputs in RUN, evaluated by priority (Mealy):
  1. memstall: all enables 0, no flushes; next state MEM_WAIT; wait timer loads 1.
  2. else ex_branch_taken: pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1, exmem_en=1.
  3. else lu: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1 (exactly one bubble; on the next cycle EX holds the NOP, so lu clears).
  4. else: all enables 1, no flushes.
- A branch and lu cannot both be true, because EX holds only one instruction.
- MEM_WAIT:
  - While mem_ready=0: all enables 0, no flushes, timer increments, saturating at 255.
  - When the timer reaches MEM_TIMEOUT, mem_timeout is set on that edge. It is sticky until reset. The block keeps waiting (no abort).
  - When mem_ready=1 (release cycle): exmem_en=1, and branch/lu/normal are applied with the RUN priority rules 2–4. Next state is RUN.
- Held inputs: ex_branch_taken and lu that arrive during a memory wait are held by the frozen pipeline and take effect in the release cycle.
- stall_cycles increments on each clk edge where state!=INIT and pc_en=0. It saturates at 2^CNT_W-1.
- Reset mid-wait or mid-bubble: async return to INIT, and all outputs take their reset values immediately.

Optional Feature:
STALL_PERF_CNT_EN:
- Defined: the stall_cycles counter is implemented as described above.
- Undefined: no counter flops are present and stall_cycles is tied to 0. All other behaviour is identical.

Test Plan:
1. Reset release: hold rst_n=0 for 3 cycles, then release -> reset output values while low; RUN with all enables 1 and no flushes from the 2nd edge after release (idle inputs).
2. Load-use: ex_inst=0x0000A283 (lw x5,0(x1)) and id_inst=0x00728333 (add x6,x5,x7) -> exactly 1 cycle with pc_en=0, ifid_en=0, idex_flush=1; then with ex_inst=NOP, normal operation; stall_cycles=1.
3. No false hazards:
   - ex_inst=0x0000A003 (lw x0) with id_inst=0x00028333 -> no stall.
   - ex_inst=0x0000A283 with id_inst=0x00508313 (addi x6,x1,5; rs2 field =5) -> no stall.
4. Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 -> enables 0 for 3 cycles; release cycle has all enables 1; stall_cycles=3; mem_timeout=0.
5. Timeout plus simultaneous branch: MEM_TIMEOUT=15, mem_ready=0 for 20 cycles with ex_branch_taken=1 held -> mem_timeout rises after the 15th wait cycle and stays 1; no flush until the release cycle, where ifid_flush=idex_flush=1.
6. Reset mid-wait: assert rst_n=0 during cycle 4 of a MEM_WAIT -> outputs take reset values immediately; after release, mem_timeout=0, stall_cycles=0, and the block enters RUN normally.
